multicycle_control_unit: RTL and testbench

- Sequencing control FSM for the multi-cycle RV32I-subset core.
- Drives the ALU's `alu_op` encoding and the datapath's mux selects and write strobes, and consumes `alu_bcond` back from the ALU.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Uses a ready handshake with the unified instruction/data memory.

---
 rtl/multicycle_control_unit_if.sv | 33 +++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory.
// The master side is the control unit; the slave side is the datapath.
interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_bcond;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic        pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        is_halted;

    modport master (
        input  instr, mem_ready, alu_bcond,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_source,
        output i_or_d, mem_read, mem_write, ir_write, reg_write,
        output mem_to_reg, is_halted
    );

    modport slave (
        output instr, mem_ready, alu_bcond,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_source,
        input  i_or_d, mem_read, mem_write, ir_write, reg_write,
        input  mem_to_reg, is_halted
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM for the multi-cycle RV32I-subset core.
// Outputs are combinational from state and inputs, forced low in reset.
module multicycle_control_unit (
    input  logic clk,
    input  logic reset_n,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JUMP, S_HALT
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_AND  = 4'b0100;
    localparam logic [3:0] A_OR   = 4'b0101;
    localparam logic [3:0] A_XOR  = 4'b1000;
    localparam logic [3:0] A_SLL  = 4'b1010;
    localparam logic [3:0] A_SRL  = 4'b1011;
    localparam logic [3:0] A_ZERO = 4'b1111;

    state_e state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jalr;
    logic [3:0] arith_op, br_op, exec_op;
    logic       br_ok;
    logic       unused_instr_bits;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign f7b5    = bus.instr[30];
    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_jalr = (opcode == OP_JALR);
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15],
                                 bus.instr[11:7]};

    always_comb begin
        arith_op = A_ZERO;
        case (funct3)
            3'b000:  arith_op = (is_r && f7b5) ? A_SUB : A_ADD;
            3'b001:  arith_op = A_SLL;
            3'b100:  arith_op = A_XOR;
            3'b101:  arith_op = A_SRL;
            3'b110:  arith_op = A_OR;
            3'b111:  arith_op = A_AND;
            default: arith_op = A_ZERO;
        endcase
    end

    // Only eq/ne/lt/ge are wired to bcond; others never take.
    always_comb begin
        br_op = A_ZERO;
        br_ok = 1'b1;
        case (funct3)
            3'b000:  br_op = A_ADD;
            3'b001:  br_op = A_SLL;
            3'b100:  br_op = A_XOR;
            3'b101:  br_op = A_SRL;
            default: begin
                br_op = A_ZERO;
                br_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        exec_op = A_ADD;
        if (is_r || is_i) exec_op = arith_op;
        else if (is_br)   exec_op = br_op;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.alu_op     = A_ADD;
        bus.alu_src_a  = 2'd0;
        bus.alu_src_b  = 2'd0;
        bus.pc_write   = 1'b0;
        bus.pc_source  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 2'd0;
        bus.is_halted  = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_src_b = 2'd1;
                        state_d       = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_a = 2'd2;
                    bus.alu_src_b = 2'd2;
                    case (opcode)
                        OP_JAL:  state_d = S_JUMP;
                        OP_SYS:  state_d = S_HALT;
                        OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR:
                                 state_d = S_EXEC;
                        default: state_d = S_FETCH;
                    endcase
                end
                S_EXEC: begin
                    bus.alu_src_a = 2'd1;
                    bus.alu_src_b = (is_r || is_br) ? 2'd0 : 2'd2;
                    bus.alu_op    = exec_op;
                    state_d       = S_FETCH;
                    unique case (1'b1)
                        is_br: begin
                            bus.pc_write  = bus.alu_bcond & br_ok;
                            bus.pc_source = 1'b1;
                        end
                        is_jalr: begin
                            bus.pc_write   = 1'b1;
                            bus.reg_write  = 1'b1;
                            bus.mem_to_reg = 2'd2;
                        end
                        (is_ld || is_st): state_d = S_MEM;
                        default:          state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = is_ld;
                    bus.mem_write = is_st;
                    if (bus.mem_ready) state_d = is_ld ? S_WB : S_FETCH;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = is_ld ? 2'd1 : 2'd0;
                    state_d        = S_FETCH;
                end
                S_JUMP: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'd2;
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 1'b1;
                    state_d        = S_FETCH;
                end
                S_HALT: begin
                    bus.is_halted = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus queues per-cycle expected control vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    typedef struct {
        logic [17:0] exp;
        string       name;
    } item_t;

    item_t sbq[$];

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] ov(
        input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
        input logic pw, input logic ps, input logic iod, input logic mr,
        input logic mw, input logic irw, input logic rw,
        input logic [1:0] m2r, input logic h);
        return {op, sa, sb, pw, ps, iod, mr, mw, irw, rw, m2r, h};
    endfunction

    logic [17:0] act;
    assign act = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
                  bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                  bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.is_halted};

    localparam logic [17:0] ZERO  = 18'd0;
    logic [17:0] f_wait, f_go, dec, wb_alu, wb_ld, halt_v, jump_v;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            item_t it;
            it = sbq.pop_front();
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic step(input logic rn, input logic [31:0] ins,
                        input logic rdy, input logic bc,
                        input logic [17:0] e, input string nm);
        @(posedge clk);
        #1;
        reset_n       = rn;
        bus.instr     = ins;
        bus.mem_ready = rdy;
        bus.alu_bcond = bc;
        sbq.push_back('{e, nm});
    endtask

    task automatic fetch(input logic [31:0] ins, input string nm);
        step(1, ins, 1, 0, f_go, {nm, "/fetch"});
        step(1, ins, 1, 0, dec, {nm, "/decode"});
    endtask

    task automatic rtype(input logic [31:0] ins, input logic [3:0] op,
                         input logic [1:0] sb, input string nm);
        fetch(ins, nm);
        step(1, ins, 1, 0, ov(op, 1, sb, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             {nm, "/exec"});
        step(1, ins, 1, 0, wb_alu, {nm, "/wb"});
    endtask

    task automatic branch(input logic [31:0] ins, input logic bc,
                          input logic [3:0] op, input logic pw,
                          input string nm);
        fetch(ins, nm);
        step(1, ins, 1, bc, ov(op, 1, 0, pw, 1, 0, 0, 0, 0, 0, 0, 0),
             {nm, "/exec"});
    endtask

    initial begin
        f_wait = ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        f_go   = ov(0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        dec    = ov(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_alu = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        wb_ld  = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        halt_v = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        jump_v = ov(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 2, 0);
        bus.instr     = 32'd0;
        bus.mem_ready = 1'b1;
        bus.alu_bcond = 1'b1;

        step(0, 32'h002081B3, 1, 1, ZERO, "reset0");
        step(0, 32'h002081B3, 1, 1, ZERO, "reset1");

        rtype(32'h002081B3, 4'b0000, 0, "add");
        rtype(32'h402081B3, 4'b0001, 0, "sub");
        rtype(32'h0020E1B3, 4'b0101, 0, "or");
        rtype(32'h0020F1B3, 4'b0100, 0, "and");
        rtype(32'h0020A1B3, 4'b1111, 0, "slt_zero");
        rtype(32'h0050C193, 4'b1000, 2, "xori");
        rtype(32'h4010D193, 4'b1011, 2, "srai");
        rtype(32'h40008193, 4'b0000, 2, "addi_b30");

        branch(32'h00208463, 1, 4'b0000, 1, "beq_t");
        branch(32'h00208463, 0, 4'b0000, 0, "beq_nt");
        branch(32'h0020A463, 1, 4'b1111, 0, "br_f3_010");
        branch(32'h00209463, 1, 4'b1010, 1, "bne_t");

        // lw with three MEM stall cycles
        fetch(32'h0040A283, "lw");
        step(1, 32'h0040A283, 1, 0, ov(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             "lw/exec");
        for (int i = 0; i < 3; i++)
            step(1, 32'h0040A283, 0, 0,
                 ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "lw/mem_stall");
        step(1, 32'h0040A283, 1, 0, ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0),
             "lw/mem_go");
        step(1, 32'h0040A283, 1, 0, wb_ld, "lw/wb");

        // sw with FETCH stalled twice; mem_ready low in DECODE is ignored
        step(1, 32'h0020A423, 0, 0, f_wait, "sw/fetch_stall0");
        step(1, 32'h0020A423, 0, 0, f_wait, "sw/fetch_stall1");
        step(1, 32'h0020A423, 1, 0, f_go, "sw/fetch_go");
        step(1, 32'h0020A423, 0, 0, dec, "sw/decode");
        step(1, 32'h0020A423, 1, 0, ov(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             "sw/exec");
        step(1, 32'h0020A423, 1, 0, ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0),
             "sw/mem");

        fetch(32'h008000EF, "jal");
        step(1, 32'h008000EF, 1, 0, jump_v, "jal/jump");

        fetch(32'h000080E7, "jalr");
        step(1, 32'h000080E7, 1, 0, ov(0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 2, 0),
             "jalr/exec");

        fetch(32'h0000007F, "unknown");

        // store interrupted by reset while waiting in MEM
        fetch(32'h0020A423, "sw_rst");
        step(1, 32'h0020A423, 1, 0, ov(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             "sw_rst/exec");
        step(1, 32'h0020A423, 0, 0, ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0),
             "sw_rst/mem");
        step(0, 32'h0020A423, 1, 1, ZERO, "sw_rst/in_reset");
        step(1, 32'h0020A423, 0, 0, f_wait, "sw_rst/after");
        step(1, 32'h002081B3, 1, 0, f_go, "post_rst/fetch");
        step(1, 32'h002081B3, 1, 0, dec, "post_rst/decode");
        step(1, 32'h002081B3, 1, 0, ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             "post_rst/exec");
        step(1, 32'h002081B3, 1, 0, wb_alu, "post_rst/wb");

        fetch(32'h00000073, "ecall");
        for (int i = 0; i < 22; i++)
            step(1, 32'h00000073, i[0], i[1], halt_v, "ecall/halt");
        step(0, 32'h00000073, 1, 1, ZERO, "halt/in_reset");
        step(1, 32'h00000073, 1, 0, f_go, "halt/after_fetch");

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end
endmodule
